// File: rtl/pcie_tx_os_gen.sv
// Per-lane PCIe Gen1/Gen2 transmit ordered-set generator (TS1/TS2/FTS/EIOS/SKP) with
// link-layer pass-through; sits ahead of the lane scrambler and 8b10b encoder.
module pcie_tx_os_gen #(
  parameter int SKP_INTERVAL = 1180,
  parameter int CNT_WIDTH    = 11
) (
  input  logic                 Clk,
  input  logic                 notReset,
  input  logic                 OsReq,
  input  logic [1:0]           OsType,
  input  logic [CNT_WIDTH-1:0] OsRepeat,
  input  logic [7:0]           LinkNum,
  input  logic [7:0]           LaneNum,
  input  logic [7:0]           NFts,
  input  logic [7:0]           DataRate,
  input  logic [7:0]           LinkCtrl,
  input  logic                 SkpEnable,
  input  logic [7:0]           TxDataIn,
  input  logic                 TxCtrlIn,
  output logic                 TxDataRd,
  output logic                 OsAck,
  output logic                 OsBusy,
  output logic [7:0]           TxByte,
  output logic                 TxControl
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TS    = 2'd1;
  localparam logic [1:0] SHORT = 2'd2;

  localparam logic [1:0] TYPE_TS2  = 2'd1;
  localparam logic [1:0] TYPE_FTS  = 2'd2;
  localparam logic [1:0] TYPE_EIOS = 2'd3;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_FTS = 8'h3C;
  localparam logic [7:0] SYM_IDL = 8'h7C;
  localparam logic [7:0] TS1_ID  = 8'h4A;
  localparam logic [7:0] TS2_ID  = 8'h45;

  localparam logic [CNT_WIDTH-1:0] SKP_LAST = CNT_WIDTH'(SKP_INTERVAL - 1);

  logic [1:0]           state;
  logic [3:0]           symIdx;
  logic [1:0]           curType;
  logic [7:0]           shortSym;
  logic [CNT_WIDTH-1:0] repLeft;
  logic [CNT_WIDTH-1:0] skpCnt;
  logic                 skpPending;

  logic [7:0] linkNumQ, laneNumQ, nFtsQ, dataRateQ, linkCtrlQ;

  logic       lastSym, boundary, skpDue;
  logic       startSkp, startRep, startNew, startOs;
  logic [1:0] typeSel;
  logic [3:0] nextIdx;
  logic [7:0] nextSym;

  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

  // A new ordered set may only begin when idle or on the final symbol of the current one.
  assign lastSym  = ((state == TS) && (symIdx == 4'd15)) || ((state == SHORT) && (symIdx == 4'd3));
  assign boundary = (state == IDLE) || lastSym;
  assign skpDue   = skpPending & SkpEnable;
  assign startSkp = boundary & skpDue;
  assign startRep = boundary & ~skpDue & (repLeft != '0);
  assign startNew = (state == IDLE) & ~skpDue & (repLeft == '0) & OsReq;
  assign startOs  = startSkp | startRep | startNew;
  assign typeSel  = startNew ? OsType : curType;
  assign nextIdx  = symIdx + 4'd1;

  assign TxDataRd = (state == IDLE) & ~startOs;
  assign OsBusy   = (state != IDLE);

  always_comb begin
    nextSym = shortSym;
    if (state == TS) begin
      case (nextIdx)
        4'd1:    nextSym = linkNumQ;
        4'd2:    nextSym = laneNumQ;
        4'd3:    nextSym = nFtsQ;
        4'd4:    nextSym = dataRateQ;
        4'd5:    nextSym = linkCtrlQ;
        default: nextSym = (curType == TYPE_TS2) ? TS2_ID : TS1_ID;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      state      <= IDLE;
      symIdx     <= 4'd0;
      curType    <= 2'd0;
      shortSym   <= 8'h00;
      repLeft    <= '0;
      skpCnt     <= '0;
      skpPending <= 1'b0;
      OsAck      <= 1'b0;
      TxByte     <= 8'h00;
      TxControl  <= 1'b0;
    end else begin
      OsAck <= startNew;

      if (startOs) begin
        TxByte    <= SYM_COM;
        TxControl <= 1'b1;
        symIdx    <= 4'd0;
        if (startSkp) begin
          state    <= SHORT;
          shortSym <= SYM_SKP;
        end else if (typeSel == TYPE_FTS) begin
          state    <= SHORT;
          shortSym <= SYM_FTS;
        end else if (typeSel == TYPE_EIOS) begin
          state    <= SHORT;
          shortSym <= SYM_IDL;
        end else begin
          state <= TS;
        end
      end else if ((state != IDLE) && !lastSym) begin
        symIdx    <= nextIdx;
        TxByte    <= nextSym;
        TxControl <= (state == SHORT);
      end else begin
        state     <= IDLE;
        symIdx    <= 4'd0;
        TxByte    <= TxDataIn;
        TxControl <= TxCtrlIn;
      end

      // Zero repeat count means a single copy; repLeft tracks copies still owed after this one.
      if (startNew) begin
        curType <= OsType;
        repLeft <= (OsRepeat == '0) ? '0 : OsRepeat - CNT_WIDTH'(1);
      end else if (startRep) begin
        repLeft <= repLeft - CNT_WIDTH'(1);
      end

      if (!SkpEnable || startSkp) begin
        skpCnt     <= '0;
        skpPending <= 1'b0;
      end else begin
        skpCnt <= satInc(skpCnt);
        if (skpCnt == SKP_LAST) skpPending <= 1'b1;
      end
    end
  end

  // Training-set fields are frozen at acceptance so caller changes cannot corrupt a sequence.
  always_ff @(posedge Clk) begin
    if (startNew) begin
      linkNumQ  <= LinkNum;
      laneNumQ  <= LaneNum;
      nFtsQ     <= NFts;
      dataRateQ <= DataRate;
      linkCtrlQ <= LinkCtrl;
    end
  end

endmodule

// File: tb/tb_pcie_tx_os_gen.sv
// Randomized and directed bench for pcie_tx_os_gen against a symbol-queue reference model.
module tb_pcie_tx_os_gen;

  localparam int SKPI = 20;

  logic        Clk = 1'b0;
  logic        notReset;
  logic        req;
  logic [1:0]  typ;
  logic [10:0] rep;
  logic [7:0]  link, lane, nfts, rate, ctrl;
  logic        skpEn;
  logic [7:0]  din;
  logic        cin;
  logic        TxDataRd, OsAck, OsBusy, TxControl;
  logic [7:0]  TxByte;

  pcie_tx_os_gen #(.SKP_INTERVAL(SKPI), .CNT_WIDTH(11)) dut (
    .Clk(Clk), .notReset(notReset), .OsReq(req), .OsType(typ), .OsRepeat(rep),
    .LinkNum(link), .LaneNum(lane), .NFts(nfts), .DataRate(rate), .LinkCtrl(ctrl),
    .SkpEnable(skpEn), .TxDataIn(din), .TxCtrlIn(cin), .TxDataRd(TxDataRd),
    .OsAck(OsAck), .OsBusy(OsBusy), .TxByte(TxByte), .TxControl(TxControl)
  );

  always #5 Clk = ~Clk;

  int nChk = 0;
  int nPass = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else nPass++;
  endtask

  // Reference model: the remaining symbols of the ordered set in flight live in a queue.
  logic [8:0] q[$];
  bit         mInOs, mPend, mAck;
  int         mRep, mCnt, mType;
  logic [7:0] mLink, mLane, mNfts, mRate, mCtrl;
  logic [7:0] expByte;
  logic       expK;
  int         ackSeen, busySeen, skpSeen;

  task automatic modelReset();
    q.delete();
    mInOs = 0; mPend = 0; mAck = 0; mRep = 0; mCnt = 0; mType = 0;
    expByte = 8'h00; expK = 1'b0;
  endtask

  // t: 0 TS1, 1 TS2, 2 FTS, 3 EIOS, 4 SKP
  task automatic pushOs(input int t);
    logic [7:0] fill;
    q.push_back({1'b1, 8'hBC});
    if (t < 2) begin
      q.push_back({1'b0, mLink});
      q.push_back({1'b0, mLane});
      q.push_back({1'b0, mNfts});
      q.push_back({1'b0, mRate});
      q.push_back({1'b0, mCtrl});
      for (int i = 0; i < 10; i++) q.push_back({1'b0, (t == 1) ? 8'h45 : 8'h4A});
    end else begin
      fill = (t == 2) ? 8'h3C : (t == 3) ? 8'h7C : 8'h1C;
      for (int i = 0; i < 3; i++) q.push_back({1'b1, fill});
    end
  endtask

  task automatic modelEdge();
    bit skpDue, skpCom;
    logic [8:0] s;
    skpDue = mPend && skpEn;
    skpCom = 0;
    mAck = 0;
    if (q.size() == 0) begin
      if (skpDue) begin
        pushOs(4);
        skpCom = 1;
      end else if (mRep > 0) begin
        mRep--;
        pushOs(mType);
      end else if (!mInOs && req) begin
        mType = int'(typ);
        mLink = link; mLane = lane; mNfts = nfts; mRate = rate; mCtrl = ctrl;
        mRep = (rep == 0) ? 0 : int'(rep) - 1;
        pushOs(mType);
        mAck = 1;
      end
    end
    if (q.size() > 0) begin
      s = q.pop_front();
      expByte = s[7:0];
      expK = s[8];
      mInOs = 1;
    end else begin
      expByte = din;
      expK = cin;
      mInOs = 0;
    end
    if (!skpEn || skpCom) begin
      mCnt = 0;
      mPend = 0;
    end else begin
      if (mCnt == SKPI - 1) mPend = 1;
      if (mCnt < 2047) mCnt++;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle();
    bit expRd;
    checkEq("TxByte", TxByte, expByte);
    checkEq("TxControl", TxControl, expK);
    checkEq("OsAck", OsAck, mAck);
    checkEq("OsBusy", OsBusy, mInOs);
    if (OsAck) ackSeen++;
    if (OsBusy) busySeen++;
    if (OsBusy && TxControl && TxByte == 8'h1C) skpSeen++;
    if (mAck) req = 1'b0;
    din = 8'($urandom);
    cin = 1'($urandom);
    #1;
    expRd = !mInOs && !(mPend && skpEn) && !req;
    checkEq("TxDataRd", TxDataRd, expRd);
    modelEdge();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic runIdle(input string tag);
    int guard = 0;
    cycle();
    while ((mInOs || req || q.size() != 0) && guard < 2000) begin
      cycle();
      guard++;
    end
    checkEq(tag, guard < 2000, 1);
    repeat (2) cycle();
  endtask

  task automatic request(input logic [1:0] t, input logic [10:0] r);
    typ = t; rep = r; req = 1'b1;
  endtask

  initial begin
    int guard;
    notReset = 1'b0;
    req = 0; typ = 0; rep = 0; link = 0; lane = 0; nfts = 0; rate = 0; ctrl = 0;
    skpEn = 0; din = 0; cin = 0;
    ackSeen = 0; busySeen = 0; skpSeen = 0;
    modelReset();
    repeat (2) @(negedge Clk);
    notReset = 1'b1;
    repeat (3) cycle();

    // TS1 with PAD link/lane
    link = 8'hF7; lane = 8'hF7; nfts = 8'h18; rate = 8'h02; ctrl = 8'h00;
    request(2'd0, 11'd1);
    runIdle("ts1Done");

    // TS2 x3: one acknowledge, 48 busy cycles
    ackSeen = 0; busySeen = 0;
    link = 8'h00; lane = 8'h05; nfts = 8'h20; rate = 8'h06; ctrl = 8'h08;
    request(2'd1, 11'd3);
    runIdle("ts2Done");
    checkEq("ts2AckCount", ackSeen, 1);
    checkEq("ts2BusyCycles", busySeen, 48);

    // Reset while showing TS symbol 7
    request(2'd0, 11'd1);
    guard = 0;
    while (q.size() != 8 && guard < 100) begin
      cycle();
      guard++;
    end
    checkEq("reachIdx7", guard < 100, 1);
    checkEq("idx7Byte", TxByte, 8'h4A);
    notReset = 1'b0;
    #1;
    checkEq("rstTxByte", TxByte, 8'h00);
    checkEq("rstTxControl", TxControl, 1'b0);
    checkEq("rstOsBusy", OsBusy, 1'b0);
    checkEq("rstOsAck", OsAck, 1'b0);
    modelReset();
    req = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    notReset = 1'b1;
    request(2'd0, 11'd1);
    runIdle("restartDone");

    // Scheduled SKP between TS1 copies
    skpEn = 1'b1;
    skpSeen = 0;
    request(2'd0, 11'd4);
    runIdle("skpTsDone");
    checkEq("skpInserted", skpSeen > 0, 1);

    // EIOS then pass-through
    request(2'd3, 11'd1);
    runIdle("eiosDone");

    // FTS with SKP disabled
    skpEn = 1'b0;
    repeat (2) cycle();
    skpSeen = 0;
    request(2'd2, 11'd0);
    runIdle("ftsDone");
    checkEq("ftsNoSkp", skpSeen, 0);

    // Random traffic
    skpEn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!req) begin
        link = 8'($urandom); lane = 8'($urandom); nfts = 8'($urandom);
        rate = 8'($urandom); ctrl = 8'($urandom);
        typ = 2'($urandom); rep = 11'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) req = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) skpEn = ~skpEn;
      cycle();
    end
    req = 1'b0;
    runIdle("randDone");

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
